// File: rtl/router_rx_controller.sv
// rtl/router_rx_controller.sv - receive-side packet drain: decap trigger, header check, arbiter handshake, payload write
module router_rx_controller #(
  parameter int AURORA_DATA_WIDTH      = 64,
  parameter int ADDR_WIDTH             = 10,
  parameter int NUMBER_PACKET          = 19,
  parameter int RECOGNIZE_ROUTER_WIDTH = 2,
  parameter int PKT_WORDS              = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              empty_output_port_0,
  output logic                              rd_output_port_0,
  input  logic [AURORA_DATA_WIDTH-1:0]      data_output_port_0,
  output logic                              start_decap_pkt,
  input  logic                              done_decap_pkt,
  input  logic [8:0]                        header_pkt_recv,
  input  logic [ADDR_WIDTH-1:0]             dst_addr_arbiter_recv,
  output logic                              arbiter_write_req,
  input  logic                              arbiter_write_gnt,
  output logic [ADDR_WIDTH-1:0]             arbiter_dst_addr,
  output logic                              mem_wr_en,
  output logic [ADDR_WIDTH-1:0]             mem_wr_addr,
  output logic [AURORA_DATA_WIDTH-1:0]      mem_wr_data,
  output logic                              rx_done,
  output logic                              rx_seq_err,
  output logic [RECOGNIZE_ROUTER_WIDTH-1:0] rx_src_router,
  output logic [1:0]                        rx_ttl
);

  localparam int CW = $clog2(PKT_WORDS + 1);

  typedef enum logic [2:0] {
    IDLE, START_DECAP, WAIT_DECAP, WRITE_REQ, WRITE_DATA, DONE
  } state_t;

  state_t                            state;
  logic [CW-1:0]                     rd_cnt;
  logic [CW-1:0]                     wr_cnt;
  logic [ADDR_WIDTH-1:0]             base_addr;
  logic [4:0]                        pkt_num;
  logic [4:0]                        exp_num;
  logic [1:0]                        ttl_q;
  logic [RECOGNIZE_ROUTER_WIDTH-1:0] src_q;

  // Read strobe reacts to the FIFO flag in the same cycle so a drained FIFO never over-reads.
  assign rd_output_port_0 = (state == WRITE_DATA) && !empty_output_port_0 &&
                            (rd_cnt < CW'(PKT_WORDS));
  // FIFO data arrives the cycle after the read, aligned with the registered write strobe.
  assign mem_wr_data = mem_wr_en ? data_output_port_0 : '0;
  assign mem_wr_addr = mem_wr_en ? base_addr + ADDR_WIDTH'(wr_cnt) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      rd_cnt            <= '0;
      wr_cnt            <= '0;
      base_addr         <= '0;
      pkt_num           <= '0;
      exp_num           <= 5'd1;
      ttl_q             <= '0;
      src_q             <= '0;
      start_decap_pkt   <= 1'b0;
      arbiter_write_req <= 1'b0;
      arbiter_dst_addr  <= '0;
      mem_wr_en         <= 1'b0;
      rx_done           <= 1'b0;
      rx_seq_err        <= 1'b0;
      rx_src_router     <= '0;
      rx_ttl            <= '0;
    end else begin
      start_decap_pkt <= 1'b0;
      rx_done         <= 1'b0;
      rx_seq_err      <= 1'b0;
      mem_wr_en       <= rd_output_port_0;
      if (rd_output_port_0) rd_cnt <= rd_cnt + 1'b1;
      if (mem_wr_en)        wr_cnt <= wr_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (!empty_output_port_0) begin
            state           <= START_DECAP;
            start_decap_pkt <= 1'b1;
          end
        end
        START_DECAP: state <= WAIT_DECAP;
        WAIT_DECAP: begin
          if (done_decap_pkt) begin
            base_addr         <= dst_addr_arbiter_recv;
            ttl_q             <= header_pkt_recv[8:7];
            pkt_num           <= header_pkt_recv[6:2];
            src_q             <= header_pkt_recv[RECOGNIZE_ROUTER_WIDTH-1:0];
            arbiter_write_req <= 1'b1;
            arbiter_dst_addr  <= dst_addr_arbiter_recv;
            rd_cnt            <= '0;
            wr_cnt            <= '0;
            state             <= WRITE_REQ;
          end
        end
        WRITE_REQ: begin
          if (arbiter_write_gnt) state <= WRITE_DATA;
        end
        WRITE_DATA: begin
          if (mem_wr_en && (wr_cnt == CW'(PKT_WORDS - 1))) begin
            state             <= DONE;
            arbiter_write_req <= 1'b0;
            arbiter_dst_addr  <= '0;
            rx_done           <= 1'b1;
            rx_seq_err        <= (pkt_num != exp_num);
            // Following the received number also resynchronises after a sequence error.
            exp_num           <= (pkt_num == 5'(NUMBER_PACKET)) ? 5'd1 : pkt_num + 5'd1;
            rx_src_router     <= src_q;
            rx_ttl            <= ttl_q;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_rx_controller.sv
// tb/tb_router_rx_controller.sv - randomized bench for router_rx_controller against a packet-level reference model
module tb_router_rx_controller;

  localparam int DW = 64;
  localparam int AW = 10;
  localparam int NP = 19;
  localparam int RW = 2;
  localparam int PW = 16;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          empty_output_port_0;
  logic          rd_output_port_0;
  logic [DW-1:0] data_output_port_0 = '0;
  logic          start_decap_pkt;
  logic          done_decap_pkt = 1'b0;
  logic [8:0]    header_pkt_recv;
  logic [AW-1:0] dst_addr_arbiter_recv;
  logic          arbiter_write_req;
  logic          arbiter_write_gnt = 1'b0;
  logic [AW-1:0] arbiter_dst_addr;
  logic          mem_wr_en;
  logic [AW-1:0] mem_wr_addr;
  logic [DW-1:0] mem_wr_data;
  logic          rx_done;
  logic          rx_seq_err;
  logic [RW-1:0] rx_src_router;
  logic [1:0]    rx_ttl;

  router_rx_controller #(
    .AURORA_DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUMBER_PACKET(NP),
    .RECOGNIZE_ROUTER_WIDTH(RW), .PKT_WORDS(PW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .empty_output_port_0(empty_output_port_0), .rd_output_port_0(rd_output_port_0),
    .data_output_port_0(data_output_port_0),
    .start_decap_pkt(start_decap_pkt), .done_decap_pkt(done_decap_pkt),
    .header_pkt_recv(header_pkt_recv), .dst_addr_arbiter_recv(dst_addr_arbiter_recv),
    .arbiter_write_req(arbiter_write_req), .arbiter_write_gnt(arbiter_write_gnt),
    .arbiter_dst_addr(arbiter_dst_addr),
    .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
    .rx_done(rx_done), .rx_seq_err(rx_seq_err),
    .rx_src_router(rx_src_router), .rx_ttl(rx_ttl)
  );

  always #5 clk = ~clk;

  int vecs = 0;
  int errs = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Output-port FIFO model: data valid the cycle after a read, optional 3-cycle empty gap.
  logic [DW-1:0] fmem [0:63];
  int fwp = 0, frp = 0, nread = 0, stall_at = -1, stall_left = 0;
  logic flush = 1'b0;
  assign empty_output_port_0 = (frp == fwp) || (stall_left != 0);
  always @(posedge clk) begin
    if (flush) frp <= fwp;
    else if (rd_output_port_0) begin
      data_output_port_0 <= fmem[frp[5:0]];
      frp   <= frp + 1;
      nread <= nread + 1;
      if (nread + 1 == stall_at) stall_left <= 3;
    end else if (stall_left > 0) stall_left <= stall_left - 1;
  end

  // Decapsulator: done pulse two cycles after the start pulse.
  int dcnt = 0;
  always @(posedge clk) begin
    done_decap_pkt <= 1'b0;
    if (start_decap_pkt) dcnt <= 2;
    else if (dcnt > 0) begin
      dcnt <= dcnt - 1;
      if (dcnt == 1) done_decap_pkt <= 1'b1;
    end
  end

  // Arbiter: grant after gnt_delay cycles of request, held until request drops.
  int gnt_delay = 0, gcnt = 0;
  always @(posedge clk) begin
    if (!arbiter_write_req) begin
      arbiter_write_gnt <= 1'b0;
      gcnt <= 0;
    end else if (gcnt >= gnt_delay) arbiter_write_gnt <= 1'b1;
    else gcnt <= gcnt + 1;
  end

  // Monitor: everything recorded here only grows, tasks take snapshots.
  logic [AW-1:0] cap_addr [0:1023];
  logic [DW-1:0] cap_data [0:1023];
  int cap_n = 0, done_cnt = 0, done_cyc = 0, gnt_cyc = 0, req_cyc = 0, viol = 0;
  logic done_err, prev_gnt = 1'b0, prev_req = 1'b0;
  logic [RW-1:0] done_src;
  logic [1:0] done_ttl;
  always @(negedge clk) begin
    if (mem_wr_en && cap_n < 1024) begin
      cap_addr[cap_n] = mem_wr_addr;
      cap_data[cap_n] = mem_wr_data;
      cap_n = cap_n + 1;
    end
    if (rx_done) begin
      done_cnt = done_cnt + 1;
      done_err = rx_seq_err;
      done_src = rx_src_router;
      done_ttl = rx_ttl;
      done_cyc = cyc;
    end
    if (arbiter_write_gnt && !prev_gnt) gnt_cyc = cyc;
    if (arbiter_write_req && !prev_req) req_cyc = cyc;
    if (arbiter_write_req && !arbiter_write_gnt && (rd_output_port_0 || mem_wr_en)) viol = viol + 1;
    prev_gnt = arbiter_write_gnt;
    prev_req = arbiter_write_req;
  end

  // Reference model state
  logic [DW-1:0] exp_words [0:PW-1];
  int exp_num_m = 1;
  int c0, d0, v0;
  logic exp_err;

  task automatic model_done(input int num);
    exp_err   = (num != exp_num_m);
    exp_num_m = (num == NP) ? 1 : num + 1;
  endtask

  task automatic send_packet(input logic [8:0] hdr, input logic [AW-1:0] base,
                             input int gdel, input int stall_after);
    @(negedge clk);
    header_pkt_recv       = hdr;
    dst_addr_arbiter_recv = base;
    gnt_delay = gdel;
    stall_at  = (stall_after >= 0) ? nread + stall_after + 1 : -1;
    c0 = cap_n; d0 = done_cnt; v0 = viol;
    for (int i = 0; i < PW; i++) begin
      exp_words[i] = {$urandom, $urandom};
      fmem[6'(fwp + i)] = exp_words[i];
    end
    fwp = fwp + PW;
    for (int t = 0; t < 300 && done_cnt == d0; t++) @(negedge clk);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_payload(input string name, input logic [AW-1:0] base);
    vecs++;
    if (cap_n - c0 !== PW) begin
      errs++;
      $display("FAIL %s_count: got %0d writes want %0d", name, cap_n - c0, PW);
    end
    for (int i = 0; i < PW; i++) begin
      logic [AW-1:0] ea;
      ea = AW'((int'(base) + i) % (1 << AW));
      vecs++;
      if (cap_addr[c0+i] !== ea || cap_data[c0+i] !== exp_words[i]) begin
        errs++;
        $display("FAIL %s_wr%0d: got %h/%h want %h/%h", name, i, cap_addr[c0+i], cap_data[c0+i], ea, exp_words[i]);
      end
    end
    vecs++;
    if (done_cnt - d0 !== 1 || done_err !== exp_err) begin
      errs++;
      $display("FAIL %s_done: got pulses=%0d err=%b want 1/%b", name, done_cnt - d0, done_err, exp_err);
    end
  endtask

  task automatic test_reset;
    logic [127:0] outs;
    rst_n = 1'b0;
    header_pkt_recv = '0;
    dst_addr_arbiter_recv = '0;
    repeat (3) @(negedge clk);
    outs = {rd_output_port_0, start_decap_pkt, arbiter_write_req, arbiter_dst_addr, mem_wr_en,
            mem_wr_addr, mem_wr_data, rx_done, rx_seq_err, rx_src_router, rx_ttl};
    vecs++;
    if (outs !== '0) begin errs++; $display("FAIL reset_outputs: got %h want 0", outs); end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    vecs++;
    if (start_decap_pkt !== 1'b0 || arbiter_write_req !== 1'b0) begin
      errs++; $display("FAIL idle_empty: got start=%b req=%b want 0/0", start_decap_pkt, arbiter_write_req);
    end
  endtask

  task automatic test_single;
    send_packet(9'b10_00001_01, 10'h100, 0, -1);
    model_done(1);
    check_payload("single", 10'h100);
    vecs++;
    if (done_src !== 2'd1 || done_ttl !== 2'd2) begin
      errs++; $display("FAIL single_hdr: got src=%0d ttl=%0d want 1/2", done_src, done_ttl);
    end
    vecs++;
    if (done_cyc - gnt_cyc !== PW + 2) begin
      errs++; $display("FAIL single_latency: got %0d want %0d", done_cyc - gnt_cyc, PW + 2);
    end
  endtask

  task automatic test_grant_delay;
    logic [4:0] n;
    n = 5'($urandom_range(1, NP));
    send_packet({2'($urandom), n, 2'($urandom)}, 10'h100, 5, -1);
    model_done(int'(n));
    check_payload("gdelay", 10'h100);
    vecs++;
    if (viol - v0 !== 0 || gnt_cyc - req_cyc !== 6) begin
      errs++; $display("FAIL gdelay_hold: got early=%0d req_to_gnt=%0d want 0/6", viol - v0, gnt_cyc - req_cyc);
    end
    vecs++;
    if (done_cyc - gnt_cyc !== PW + 2) begin
      errs++; $display("FAIL gdelay_latency: got %0d want %0d", done_cyc - gnt_cyc, PW + 2);
    end
  endtask

  task automatic test_fifo_stall;
    logic [4:0] n;
    logic [AW-1:0] b;
    n = 5'($urandom_range(1, NP));
    b = AW'($urandom_range(0, 1000));
    send_packet({2'($urandom), n, 2'($urandom)}, b, 0, 7);
    model_done(int'(n));
    check_payload("stall", b);
    vecs++;
    if (done_cyc - gnt_cyc !== PW + 2 + 3) begin
      errs++; $display("FAIL stall_latency: got %0d want %0d", done_cyc - gnt_cyc, PW + 5);
    end
  endtask

  task automatic test_addr_wrap;
    send_packet({2'($urandom), 5'd19, 2'($urandom)}, 10'h3F8, 0, -1);
    model_done(19);
    check_payload("wrap", 10'h3F8);
  endtask

  task automatic test_back_to_back_seq;
    int nums [$];
    for (int i = 1; i <= NP; i++) nums.push_back(i);
    nums.push_back(1);
    nums.push_back(5);
    nums.push_back(6);
    foreach (nums[k]) begin
      logic [1:0] ttl;
      logic [RW-1:0] src;
      logic [AW-1:0] b;
      ttl = 2'($urandom);
      src = RW'($urandom);
      b = AW'($urandom);
      send_packet({ttl, 5'(nums[k]), src}, b, $urandom_range(0, 2), -1);
      model_done(nums[k]);
      check_payload($sformatf("seq%0d", k), b);
      vecs++;
      if (done_src !== src || done_ttl !== ttl) begin
        errs++; $display("FAIL seq%0d_hdr: got %0d/%0d want %0d/%0d", k, done_src, done_ttl, src, ttl);
      end
    end
  endtask

  task automatic test_reset_midpacket;
    logic [127:0] outs;
    int t;
    @(negedge clk);
    header_pkt_recv = {2'd3, 5'd9, 2'd2};
    dst_addr_arbiter_recv = 10'h055;
    gnt_delay = 0;
    stall_at = -1;
    c0 = cap_n;
    for (int i = 0; i < PW; i++) fmem[6'(fwp + i)] = {$urandom, $urandom};
    fwp = fwp + PW;
    for (t = 0; t < 300 && cap_n - c0 < 5; t++) @(negedge clk);
    vecs++;
    if (cap_n - c0 < 5) begin errs++; $display("FAIL midreset_progress: got %0d writes want 5", cap_n - c0); end
    rst_n = 1'b0;
    #1;
    outs = {rd_output_port_0, start_decap_pkt, arbiter_write_req, arbiter_dst_addr, mem_wr_en,
            mem_wr_addr, mem_wr_data, rx_done, rx_seq_err, rx_src_router, rx_ttl};
    vecs++;
    if (outs !== '0) begin errs++; $display("FAIL midreset_outputs: got %h want 0", outs); end
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    exp_num_m = 1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    send_packet({2'd1, 5'd1, 2'd3}, 10'h200, 1, -1);
    model_done(1);
    check_payload("after_reset", 10'h200);
  endtask

  initial begin
    test_reset;
    test_single;
    test_grant_delay;
    test_fifo_stall;
    test_addr_wrap;
    test_back_to_back_seq;
    test_reset_midpacket;
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
